// File: rtl/adder_tree_scheduler.sv
// rtl/adder_tree_scheduler.sv - round-robin time-sharing of one external adder tree with per-burst accumulation
module adder_tree_scheduler #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_INPUTS = 9,
    parameter  int NUM_REQ    = 4,
    parameter  int ID_WIDTH   = 2,
    parameter  int ACC_WIDTH  = 48,
    localparam int SUM_WIDTH  = NUM_INPUTS + DATA_WIDTH + 1,
    localparam int VEC_WIDTH  = NUM_INPUTS * DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*VEC_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [VEC_WIDTH-1:0]         tree_in_data,
    input  logic [SUM_WIDTH-1:0]         tree_out_data,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [ACC_WIDTH-1:0]         res_data,
    output logic [ID_WIDTH-1:0]          res_id,
    output logic                         res_ovf,
    output logic                         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SUM  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic                  first;
    logic                  last_reg;

    logic                  pick_found;
    logic [ID_WIDTH-1:0]   pick_id;
    logic [NUM_REQ-1:0]    pick_onehot;
    logic [NUM_REQ-1:0]    grant_onehot;
    logic                  sel_valid;
    logic                  sel_last;
    logic [VEC_WIDTH-1:0]  sel_data;
    logic [ACC_WIDTH:0]    acc_base;
    logic [ACC_WIDTH:0]    acc_next;

    // Round-robin scan starting one past the previous winner.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!pick_found && (r == (int'(rr_ptr) + i) % NUM_REQ) && req_valid[r]) begin
                    pick_found = 1'b1;
                    pick_id    = ID_WIDTH'(r);
                end
            end
        end
    end

    // res_id doubles as the latched grant for the whole burst.
    always_comb begin
        pick_onehot  = '0;
        grant_onehot = '0;
        sel_valid    = 1'b0;
        sel_last     = 1'b0;
        sel_data     = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (pick_id == ID_WIDTH'(r)) begin
                pick_onehot[r] = 1'b1;
            end
            if (res_id == ID_WIDTH'(r)) begin
                grant_onehot[r] = 1'b1;
                sel_valid       = req_valid[r];
                sel_last        = req_last[r];
                sel_data        = req_data[r*VEC_WIDTH +: VEC_WIDTH];
            end
        end
    end

    // One extra bit catches the carry out of the accumulator.
    always_comb begin
        acc_base = first ? '0 : {1'b0, res_data};
        acc_next = acc_base + (ACC_WIDTH+1)'(tree_out_data);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= ID_WIDTH'(NUM_REQ - 1);
            first        <= 1'b1;
            last_reg     <= 1'b0;
            req_ready    <= '0;
            tree_in_data <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_id       <= '0;
            res_ovf      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        res_id    <= pick_id;
                        req_ready <= pick_onehot;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (sel_valid) begin
                        tree_in_data <= sel_data;
                        last_reg     <= sel_last;
                        req_ready    <= '0;
                        state        <= SUM;
                    end
                end
                SUM: begin
                    res_data <= acc_next[ACC_WIDTH-1:0];
                    res_ovf  <= (first ? 1'b0 : res_ovf) | acc_next[ACC_WIDTH];
                    first    <= 1'b0;
                    if (last_reg) begin
                        res_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        req_ready <= grant_onehot;
                        state     <= LOAD;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        rr_ptr    <= res_id;
                        first     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
